// File: rtl/display_sequencer.sv
// display_sequencer: steps the display mux between A, B and test pattern on a debounced button
module display_sequencer #(
  parameter int DEBOUNCE_CYCLES  = 1000,
  parameter int DEB_W            = 10,
  parameter int TEST_HOLD_CYCLES = 4096,
  parameter int HOLD_W           = 13
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_next,
  input  logic       result_valid,
  output logic [1:0] display_select,
  output logic       sel_changed
);
  typedef enum logic [1:0] {
    SHOW_A    = 2'd0,
    SHOW_B    = 2'd1,
    SHOW_TEST = 2'd2
  } state_t;
  state_t            state_q, state_d;
  logic              s1_q, s2_q, deb_q, deb_d, deb_prev_q, chg_q;
  logic              press, timeout, dcnt_full;
  logic [DEB_W-1:0]  dcnt_q, dcnt_d;
  logic [HOLD_W-1:0] hcnt_q, hcnt_d;
  // next-state: debounce counter, press edge, mode selection with result_valid > press > timeout
  always_comb begin
    dcnt_full = dcnt_q == DEB_W'(DEBOUNCE_CYCLES - 1);
    deb_d     = (s2_q != deb_q && dcnt_full) ? s2_q : deb_q;
    dcnt_d    = (s2_q == deb_q || dcnt_full) ? '0 : dcnt_q + 1'b1;
    press     = deb_q & ~deb_prev_q;
    timeout   = state_q == SHOW_TEST && hcnt_q == HOLD_W'(TEST_HOLD_CYCLES - 1);
    state_d   = result_valid ? SHOW_B :
                press        ? (state_q == SHOW_A ? SHOW_B : state_q == SHOW_B ? SHOW_TEST : SHOW_A) :
                timeout      ? SHOW_A : state_q;
    hcnt_d    = (state_q == SHOW_TEST && state_d == SHOW_TEST) ? hcnt_q + 1'b1 : '0;
  end
  // all state and registered outputs; reset clears everything including the synchroniser
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
      dcnt_q     <= '0;
      hcnt_q     <= '0;
      state_q    <= SHOW_A;
      chg_q      <= 1'b0;
    end else begin
      s1_q       <= btn_next;
      s2_q       <= s1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      dcnt_q     <= dcnt_d;
      hcnt_q     <= hcnt_d;
      state_q    <= state_d;
      chg_q      <= state_d != state_q;
    end
  end
  assign display_select = state_q;
  assign sel_changed    = chg_q;
endmodule

// File: tb/tb_display_sequencer.sv
// tb_display_sequencer: directed scenarios plus random stimulus against a behavioural model
module tb_display_sequencer;
  localparam int D = 4;
  localparam int H = 8;
  logic       clk = 1'b0, reset = 1'b1, btn_next = 1'b0, result_valid = 1'b0;
  logic [1:0] display_select;
  logic       sel_changed;
  int         vectors = 0, miscompares = 0;
  bit         sync0, sync1, m_deb, m_deb_prev, m_chg;
  int         run, m_sel, shown;

  display_sequencer #(
    .DEBOUNCE_CYCLES(D), .DEB_W(3), .TEST_HOLD_CYCLES(H), .HOLD_W(4)
  ) dut (
    .clk(clk), .reset(reset), .btn_next(btn_next), .result_valid(result_valid),
    .display_select(display_select), .sel_changed(sel_changed)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: a press is the first cycle after the synchronised level has been accepted high;
  // the mode advances A->B->TEST->A, result_valid forces B, TEST lasts at most H cycles.
  task automatic model_edge(input bit b, input bit rv, input bit rst);
    bit press;
    int nxt;
    if (rst) begin
      sync0 = 0; sync1 = 0; m_deb = 0; m_deb_prev = 0;
      run = 0; m_sel = 0; shown = 0; m_chg = 0;
    end else begin
      press = m_deb && !m_deb_prev;
      if (m_sel == 2) shown = shown + 1;
      nxt = rv ? 1 : press ? (m_sel + 1) % 3 : (m_sel == 2 && shown == H) ? 0 : m_sel;
      if (nxt != 2 || m_sel != 2) shown = 0;
      m_chg = nxt != m_sel;
      m_sel = nxt;
      m_deb_prev = m_deb;
      if (sync1 == m_deb) run = 0;
      else begin
        run = run + 1;
        if (run == D) begin
          m_deb = sync1;
          run = 0;
        end
      end
      sync1 = sync0;
      sync0 = b;
    end
  endtask

  task automatic cyc(input bit b, input bit rv, input bit rst);
    btn_next = b;
    result_valid = rv;
    reset = rst;
    model_edge(b, rv, rst);
    @(negedge clk);
    check("display_select", display_select, m_sel);
    check("sel_changed", sel_changed, m_chg);
  endtask

  task automatic press(input int hi, input int lo);
    repeat (hi) cyc(1, 0, 0);
    repeat (lo) cyc(0, 0, 0);
  endtask

  initial begin
    int cnt, seen2, hold;
    bit b, rv;
    repeat (3) cyc(0, 0, 1);
    check("reset_sel", display_select, 0);
    check("reset_chg", sel_changed, 0);
    cnt = 0;
    repeat (20) begin cyc(0, 0, 0); cnt += int'(sel_changed); end
    check("idle_changes", cnt, 0);
    check("idle_sel", display_select, 0);

    repeat (2) cyc(0, 0, 1);
    cnt = 0;
    for (int i = 1; i <= 15; i++) begin
      cyc(1, 0, 0);
      cnt += int'(sel_changed);
      if (i == 6) check("latency_before", display_select, 0);
      if (i == 7) begin
        check("latency_sel", display_select, 1);
        check("latency_pulse", sel_changed, 1);
      end
    end
    check("held_changes", cnt, 1);
    repeat (10) cyc(0, 0, 0);

    repeat (2) cyc(0, 0, 1);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      cyc((i % 5) < 3, 0, 0);
      cnt += int'(sel_changed);
    end
    check("bounce_changes", cnt, 0);
    check("bounce_sel", display_select, 0);
    repeat (10) cyc(0, 0, 0);

    press(10, 10);
    check("first_press", display_select, 1);
    seen2 = 0;
    for (int i = 0; i < 30; i++) begin
      cyc(i < 10, 0, 0);
      seen2 += int'(display_select == 2);
    end
    check("test_hold_len", seen2, H);
    check("auto_return", display_select, 0);

    press(10, 10);
    for (int j = 1; j <= 20; j++) begin
      cyc((j <= 4) || (j >= 9 && j <= 12), 0, 0);
      if (j == 7) check("enter_test", display_select, 2);
      if (j == 15) begin
        check("third_press_sel", display_select, 0);
        check("third_press_pulse", sel_changed, 1);
      end
    end

    press(10, 10);
    for (int j = 1; j <= 20; j++) begin
      rv = m_sel == 2 && m_deb && !m_deb_prev;
      cyc((j <= 4) || (j >= 9 && j <= 12), rv, 0);
      if (j == 15) check("rv_beats_press", display_select, 1);
    end
    check("rv_press_discarded", display_select, 1);
    seen2 = 0;
    for (int i = 0; i < 30; i++) begin
      cyc(i < 10, 0, 0);
      seen2 += int'(display_select == 2);
    end
    check("hold_cleared_len", seen2, H);

    repeat (3) cyc(1, 0, 1);
    cnt = 0;
    for (int i = 1; i <= 20; i++) begin
      cyc(1, 0, 0);
      cnt += int'(sel_changed);
      if (i == 7) check("reset_held_sel", display_select, 1);
    end
    check("reset_held_changes", cnt, 1);
    repeat (2) cyc(1, 1, 0);
    check("rv_in_b_no_pulse", sel_changed, 0);

    b = 0;
    hold = 0;
    repeat (3000) begin
      if (hold == 0) begin
        hold = $urandom_range(12, 1);
        b = ~b;
      end
      hold--;
      cyc(b, $urandom_range(29, 0) == 0, $urandom_range(499, 0) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
